// File: rtl/dcache_direct_pkg.sv
// Shared types and geometry defaults for the direct-mapped data cache.
`include "common.vh"
package dcache_direct_pkg;
  localparam int DCACHE_LINES = 16;
  localparam int DCACHE_WORDS = 4;
  localparam int OFFSET_BITS  = $clog2(DCACHE_WORDS);
  localparam int INDEX_BITS   = $clog2(DCACHE_LINES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } t_dcache_state;
endpackage

// File: rtl/common.vh
`ifndef COMMON_VH
`define COMMON_VH
`define V32 31:0
`endif

// File: rtl/dcache_array.sv
// Tag/valid/data storage: combinational read port, one synchronous write port, valids cleared on reset.
`include "common.vh"
module dcache_array
  import dcache_direct_pkg::*;
#(
  parameter int IDX_W = INDEX_BITS,
  parameter int OFF_W = OFFSET_BITS,
  parameter int TAG_W = 32 - INDEX_BITS - OFFSET_BITS - 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [OFF_W-1:0] rd_offset,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [`V32]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [OFF_W-1:0] wr_offset,
  input  logic [`V32]      wr_data,
  input  logic             wr_set_tag,
  input  logic [TAG_W-1:0] wr_tag
);
  localparam int LINES = 1 << IDX_W;
  localparam int DEPTH = LINES << OFF_W;

  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [`V32]      data_mem [DEPTH];
  logic [LINES-1:0] valid_q, valid_d;

  always_comb begin
    valid_d = valid_q;
    if (wr_set_tag) valid_d[wr_index] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Tag and data contents are meaningless until the valid bit is set, so they carry no reset.
  always_ff @(posedge clock) begin
    if (wr_en)      data_mem[{wr_index, wr_offset}] <= wr_data;
    if (wr_set_tag) tag_mem[wr_index] <= wr_tag;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[{rd_index, rd_offset}];
endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped write-through no-allocate D-cache: load hits in 0 cycles, misses fill a whole line.
// busy stalls the pipeline during FILL/WRITE; optional hit/miss counters under DCACHE_STATS_EN.
`include "common.vh"
module dcache_direct
  import dcache_direct_pkg::*;
#(
  parameter int LINES = DCACHE_LINES,
  parameter int WORDS = DCACHE_WORDS
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  input  logic         req_write,
  input  logic [`V32]  req_addr,
  input  logic [`V32]  req_wdata,
  output logic         busy,
  output logic [`V32]  rdata,
  output logic         mem_req,
  output logic         mem_write,
  output logic [`V32]  mem_addr,
  output logic [`V32]  mem_wdata,
  input  logic         mem_ack,
  input  logic [`V32]  mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [`V32]  hit_count,
  output logic [`V32]  miss_count
`endif
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - IDX_W - OFF_W - 2;

  t_dcache_state    state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [`V32]      addr_q, addr_d;
  logic [`V32]      wdata_q, wdata_d;

  logic [`V32]      acc_addr;
  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [`V32]      rd_data;
  logic             hit, load_hit;

  logic             arr_wr_en, arr_set_tag;
  logic [OFF_W-1:0] arr_wr_off;
  logic [`V32]      arr_wr_data;
  logic             unused_ok;

  // Once an access leaves IDLE the latched copy is used, so mid-transfer req_* changes are ignored.
  assign acc_addr  = (state_q == IDLE) ? req_addr : addr_q;
  assign req_off   = acc_addr[OFF_W+1:2];
  assign req_idx   = acc_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign req_tag   = acc_addr[31:OFF_W+IDX_W+2];
  assign unused_ok = &{1'b0, acc_addr[1:0]};

  assign hit      = rd_valid && (rd_tag == req_tag);
  assign load_hit = (state_q == IDLE) && req_valid && !req_write && hit;
  assign busy     = req_valid && !(load_hit || (state_q == DONE));
  assign rdata    = (load_hit || (state_q == DONE)) ? rd_data : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    arr_wr_en   = 1'b0;
    arr_set_tag = 1'b0;
    arr_wr_off  = cnt_q;
    arr_wr_data = mem_rdata;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_write) begin
            state_d = WRITE;
            addr_d  = {req_addr[31:2], 2'b00};
            wdata_d = req_wdata;
          end else if (!hit) begin
            state_d = FILL;
            cnt_d   = '0;
            addr_d  = {req_addr[31:2], 2'b00};
          end
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q[31:OFF_W+2], cnt_q, 2'b00};
        if (mem_ack) begin
          arr_wr_en = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == OFF_W'(WORDS - 1)) begin
            arr_set_tag = 1'b1;
            state_d     = DONE;
          end
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_ack) begin
          if (hit) begin
            arr_wr_en   = 1'b1;
            arr_wr_off  = req_off;
            arr_wr_data = wdata_q;
          end
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  dcache_array #(
    .IDX_W (IDX_W),
    .OFF_W (OFF_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clock      (clock),
    .reset      (reset),
    .rd_index   (req_idx),
    .rd_offset  (req_off),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .wr_en      (arr_wr_en & ~reset),
    .wr_index   (req_idx),
    .wr_offset  (arr_wr_off),
    .wr_data    (arr_wr_data),
    .wr_set_tag (arr_set_tag & ~reset),
    .wr_tag     (req_tag)
  );

`ifdef DCACHE_STATS_EN
  logic [`V32] hit_q, hit_d, miss_q, miss_d;

  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (load_hit) hit_d = hit_q + 32'd1;
    if ((state_q == IDLE) && (state_d == FILL)) miss_d = miss_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif
endmodule

// File: tb/tb_dcache_direct.sv
// Self-checking bench for dcache_direct: vector table plus scoreboarded memory traffic and a reset-abort sequence.
module tb_dcache_direct;
  localparam int WORDS     = 4;
  localparam int ACK_DELAY = 2;
  localparam int NVEC      = 17;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_busy;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_exp_t;

  logic        clock = 1'b0;
  logic        reset, req_valid, req_write;
  logic [31:0] req_addr, req_wdata, rdata;
  logic        busy, mem_req, mem_write, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int          n_pass = 0;
  int          n_total = 0;
  int          ack_count = 0;
  int          model_hits = 0;
  int          model_misses = 0;
  logic [31:0] exp_q [$];
  mem_exp_t    exp_mem [$];
  logic [31:0] mem_model [1024];
  vec_t        vecs [NVEC];

  always #5 clock = ~clock;

  dcache_direct dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .busy      (busy),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  function automatic logic [31:0] seed(input logic [31:0] a);
    return 32'h5A00_0000 ^ (a * 32'h0001_0003);
  endfunction

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input int exp_busy);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_busy = exp_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Backing memory: acks every ACK_DELAY-th cycle of a request and checks it against the expected traffic.
  initial begin
    mem_exp_t e;
    int wait_cnt;
    mem_ack = 1'b0;
    mem_rdata = '0;
    wait_cnt = 0;
    for (int i = 0; i < 1024; i++) mem_model[i] = seed(32'(i * 4));
    forever begin
      @(negedge clock);
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        if (wait_cnt == ACK_DELAY - 1) begin
          wait_cnt = 0;
          mem_ack = 1'b1;
          mem_rdata = mem_model[mem_addr[11:2]];
          if (mem_write) mem_model[mem_addr[11:2]] = mem_wdata;
          ack_count++;
          if (exp_mem.size() == 0) begin
            n_total++;
            $display("FAIL mem_unexpected: got access addr=%h write=%0b, expected none", mem_addr, mem_write);
          end else begin
            e = exp_mem.pop_front();
            chk("mem_write", 32'(mem_write), 32'(e.wr));
            chk("mem_addr", mem_addr, e.addr);
            if (e.wr) chk("mem_wdata", mem_wdata, e.data);
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic do_access(input vec_t v, input int id);
    mem_exp_t    e;
    int          cyc;
    logic [31:0] base;
    logic [31:0] want;
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    if (v.wr) begin
      e.wr = 1'b1; e.addr = {v.addr[31:2], 2'b00}; e.data = v.wdata;
      exp_mem.push_back(e);
    end else begin
      exp_q.push_back(v.exp_rdata);
      if (v.exp_busy != 0) begin
        base = v.addr & ~32'(WORDS * 4 - 1);
        for (int w = 0; w < WORDS; w++) begin
          e.wr = 1'b0; e.addr = base + 32'(w * 4); e.data = '0;
          exp_mem.push_back(e);
        end
        model_misses++;
      end else begin
        model_hits++;
      end
    end
    cyc = 0;
    @(negedge clock);
    while (busy !== 1'b0 && cyc < 60) begin
      cyc++;
      @(negedge clock);
    end
    chk($sformatf("v%0d_busy_cycles", id), 32'(cyc), 32'(v.exp_busy));
    if (!v.wr) begin
      want = exp_q.pop_front();
      chk($sformatf("v%0d_rdata", id), rdata, want);
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    chk($sformatf("v%0d_mem_pending", id), 32'(exp_mem.size()), 32'd0);
`ifdef DCACHE_STATS_EN
    chk($sformatf("v%0d_hit_count", id), hit_count, 32'(model_hits));
    chk($sformatf("v%0d_miss_count", id), miss_count, 32'(model_misses));
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_exp_t e;
    int       base_acks;
    vecs[0]  = mk(1'b0, 32'h040, 32'h0, seed(32'h040), 9);
    vecs[1]  = mk(1'b0, 32'h044, 32'h0, seed(32'h044), 0);
    vecs[2]  = mk(1'b1, 32'h048, 32'hDEADBEEF, 32'h0, 3);
    vecs[3]  = mk(1'b0, 32'h048, 32'h0, 32'hDEADBEEF, 0);
    vecs[4]  = mk(1'b1, 32'h200, 32'h12345678, 32'h0, 3);
    vecs[5]  = mk(1'b0, 32'h200, 32'h0, 32'h12345678, 9);
    vecs[6]  = mk(1'b0, 32'h140, 32'h0, seed(32'h140), 9);
    vecs[7]  = mk(1'b0, 32'h040, 32'h0, seed(32'h040), 9);
    vecs[8]  = mk(1'b0, 32'h04C, 32'h0, seed(32'h04C), 0);
    vecs[9]  = mk(1'b0, 32'h048, 32'h0, 32'hDEADBEEF, 0);
    vecs[10] = mk(1'b0, 32'h204, 32'h0, seed(32'h204), 0);
    vecs[11] = mk(1'b1, 32'h044, 32'hCAFEF00D, 32'h0, 3);
    vecs[12] = mk(1'b0, 32'h047, 32'h0, 32'hCAFEF00D, 0);
    vecs[13] = mk(1'b1, 32'h140, 32'h0BADCAFE, 32'h0, 3);
    vecs[14] = mk(1'b0, 32'h140, 32'h0, 32'h0BADCAFE, 9);
    vecs[15] = mk(1'b0, 32'h040, 32'h0, seed(32'h040), 9);
    vecs[16] = mk(1'b0, 32'h048, 32'h0, 32'hDEADBEEF, 0);

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
`ifdef DCACHE_STATS_EN
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
`endif
    @(posedge clock);
    #1;
    reset = 1'b0;
    req_addr = 32'h040;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk($sformatf("idle%0d_busy", k), 32'(busy), 32'd0);
      chk($sformatf("idle%0d_mem_req", k), 32'(mem_req), 32'd0);
    end
    @(posedge clock);
    #1;

    for (int i = 0; i < NVEC; i++) do_access(vecs[i], i);

    // Abort a fill with reset on its second word ack; the line must not become valid.
    base_acks = ack_count;
    for (int w = 0; w < 2; w++) begin
      e.wr = 1'b0; e.addr = 32'h300 + 32'(w * 4); e.data = '0;
      exp_mem.push_back(e);
    end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h300;
    for (int k = 0; k < 40 && ack_count < base_acks + 2; k++) begin
      @(negedge clock);
      #1;
    end
    chk("abort_acks_seen", 32'(ack_count), 32'(base_acks + 2));
    reset = 1'b1;
    req_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_hits = 0;
    model_misses = 0;
    @(negedge clock);
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mem_pending", 32'(exp_mem.size()), 32'd0);
    @(posedge clock);
    #1;
    do_access(mk(1'b0, 32'h300, 32'h0, seed(32'h300), 9), 100);
    do_access(mk(1'b0, 32'h044, 32'h0, 32'hCAFEF00D, 9), 101);
    do_access(mk(1'b0, 32'h308, 32'h0, seed(32'h308), 0), 102);

    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
